// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports and scoreboard reserve.
// Widths are packed per port, so port k occupies slice [k*W +: W] of each vector.
interface reg_file_mp_if #(
    parameter int WORD_WIDTH  = 32,
    parameter int REG_NUM_LOG = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
);
    logic [WRITE_PORTS-1:0]             writeEnable;
    logic [WRITE_PORTS*REG_NUM_LOG-1:0] writeAddr;
    logic [WRITE_PORTS*WORD_WIDTH-1:0]  writeValue;
    logic [READ_PORTS*REG_NUM_LOG-1:0]  readAddr;
    logic [READ_PORTS*WORD_WIDTH-1:0]   readValue;
    logic [READ_PORTS-1:0]              readBusy;
    logic                               reserveEnable;
    logic [REG_NUM_LOG-1:0]             reserveAddr;

    modport master (
        output writeEnable, writeAddr, writeValue, readAddr, reserveEnable, reserveAddr,
        input  readValue, readBusy
    );

    modport slave (
        input  writeEnable, writeAddr, writeValue, readAddr, reserveEnable, reserveAddr,
        output readValue, readBusy
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with async clear, write-to-read bypass, highest-port-wins
// write priority and a per-register busy scoreboard for RAW hazard detection.
module reg_file_mp #(
    parameter int WORD_WIDTH  = 32,
    parameter int REG_NUM_LOG = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int ZERO_REG    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    localparam int REG_NUM = 1 << REG_NUM_LOG;

    logic [WRITE_PORTS-1:0] wr_en;
    logic [REG_NUM_LOG-1:0] wr_addr [WRITE_PORTS];
    logic [WORD_WIDTH-1:0]  wr_data [WRITE_PORTS];

    logic [WORD_WIDTH-1:0]  regs_q [REG_NUM];
    logic [WORD_WIDTH-1:0]  regs_d [REG_NUM];
    logic [REG_NUM-1:0]     busy_q;
    logic [REG_NUM-1:0]     busy_d;

    // Strobes are masked by rst_n so the bypass cannot leak write data while held in reset.
    for (genvar k = 0; k < WRITE_PORTS; k++) begin : g_wr
        assign wr_en[k]   = bus.writeEnable[k] & rst_n;
        assign wr_addr[k] = bus.writeAddr[k*REG_NUM_LOG +: REG_NUM_LOG];
        assign wr_data[k] = bus.writeValue[k*WORD_WIDTH +: WORD_WIDTH];
    end

    // Ascending port scan lets the highest-numbered matching port override; reserve beats write clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < REG_NUM; r++) begin
            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (wr_en[k] && (wr_addr[k] == REG_NUM_LOG'(r))) begin
                    regs_d[r] = wr_data[k];
                    busy_d[r] = 1'b0;
                end
            end
            if (bus.reserveEnable && (bus.reserveAddr == REG_NUM_LOG'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Busy is the stored bit only; bypassed data is treated as valid by decode regardless.
    for (genvar j = 0; j < READ_PORTS; j++) begin : g_rd
        logic [REG_NUM_LOG-1:0] rd_addr;
        logic [WORD_WIDTH-1:0]  rd_val;

        assign rd_addr = bus.readAddr[j*REG_NUM_LOG +: REG_NUM_LOG];

        always_comb begin
            rd_val = regs_q[rd_addr];
            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (wr_en[k] && (wr_addr[k] == rd_addr)) begin
                    rd_val = wr_data[k];
                end
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_val = '0;
            end
        end

        assign bus.readValue[j*WORD_WIDTH +: WORD_WIDTH] = rd_val;
        assign bus.readBusy[j]                           = busy_q[rd_addr];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default build, a ZERO_REG=0 build and a narrow 4-read/1-write build.
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reg_file_mp_if b0 ();
    reg_file_mp_if b1 ();
    reg_file_mp_if #(.WORD_WIDTH(16), .REG_NUM_LOG(3), .READ_PORTS(4), .WRITE_PORTS(1)) b2 ();

    reg_file_mp u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    reg_file_mp #(.ZERO_REG(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    reg_file_mp #(.WORD_WIDTH(16), .REG_NUM_LOG(3), .READ_PORTS(4), .WRITE_PORTS(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input int k, input logic en, input logic [4:0] a, input logic [31:0] v);
        b0.writeEnable[k]      = en;
        b0.writeAddr[k*5 +: 5]  = a;
        b0.writeValue[k*32 +: 32] = v;
    endtask

    task automatic rsv0(input logic en, input logic [4:0] a);
        b0.reserveEnable = en;
        b0.reserveAddr   = a;
    endtask

    task automatic ra0(input int j, input logic [4:0] a);
        b0.readAddr[j*5 +: 5] = a;
    endtask

    function automatic logic [31:0] rv0(input int j);
        return b0.readValue[j*32 +: 32];
    endfunction

    function automatic logic [15:0] rv2(input int j);
        return b2.readValue[j*16 +: 16];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        b0.writeEnable = '0; b0.writeAddr = '0; b0.writeValue = '0;
        b0.readAddr = '0; b0.reserveEnable = 1'b0; b0.reserveAddr = '0;
        b1.writeEnable = '0; b1.writeAddr = '0; b1.writeValue = '0;
        b1.readAddr = '0; b1.reserveEnable = 1'b0; b1.reserveAddr = '0;
        b2.writeEnable = '0; b2.writeAddr = '0; b2.writeValue = '0;
        b2.readAddr = '0; b2.reserveEnable = 1'b0; b2.reserveAddr = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Build up state, then clear asynchronously between edges
        wr0(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wr0(0, 1'b0, 5'd0, 32'h0);
        rsv0(1'b1, 5'd10);
        tick();
        rsv0(1'b0, 5'd0);
        ra0(0, 5'd5);
        ra0(1, 5'd10);
        #1;
        check("pre_rst_r5", rv0(0), 32'hDEADBEEF);
        check("pre_rst_busy_r10", {31'd0, b0.readBusy[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_r5_val", rv0(0), 32'h0);
        check("rst_r10_busy", {31'd0, b0.readBusy[1]}, 32'd0);

        // Write pending while in reset must be lost and must not bypass
        wr0(0, 1'b1, 5'd20, 32'h00000077);
        ra0(1, 5'd20);
        #1;
        check("rst_no_bypass", rv0(1), 32'h0);
        tick();
        tick();
        wr0(0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_write_dropped", rv0(1), 32'h0);

        wr0(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wr0(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("post_rst_r5", rv0(0), 32'hDEADBEEF);

        // Bypass
        wr0(0, 1'b1, 5'd7, 32'h12345678);
        ra0(1, 5'd7);
        #1;
        check("bypass_pre_edge", rv0(1), 32'h12345678);
        tick();
        wr0(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("bypass_stored", rv0(1), 32'h12345678);

        // Port priority
        wr0(0, 1'b1, 5'd3, 32'h00001111);
        wr0(1, 1'b1, 5'd3, 32'h00002222);
        ra0(0, 5'd3);
        #1;
        check("prio_bypass", rv0(0), 32'h00002222);
        tick();
        wr0(0, 1'b0, 5'd0, 32'h0);
        wr0(1, 1'b0, 5'd0, 32'h0);
        #1;
        check("prio_stored", rv0(0), 32'h00002222);

        // Zero register
        wr0(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        rsv0(1'b1, 5'd0);
        ra0(0, 5'd0);
        #1;
        check("zero_bypass", rv0(0), 32'h0);
        tick();
        wr0(0, 1'b0, 5'd0, 32'h0);
        rsv0(1'b0, 5'd0);
        #1;
        check("zero_val", rv0(0), 32'h0);
        check("zero_busy", {31'd0, b0.readBusy[0]}, 32'd0);

        // Scoreboard on r9
        rsv0(1'b1, 5'd9);
        tick();
        rsv0(1'b0, 5'd0);
        ra0(1, 5'd9);
        #1;
        check("sb_set", {31'd0, b0.readBusy[1]}, 32'd1);
        tick();
        tick();
        #1;
        check("sb_hold", {31'd0, b0.readBusy[1]}, 32'd1);
        wr0(0, 1'b1, 5'd9, 32'h000000AB);
        #1;
        check("sb_busy_until_edge", {31'd0, b0.readBusy[1]}, 32'd1);
        check("sb_bypass_ab", rv0(1), 32'h000000AB);
        tick();
        wr0(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("sb_cleared", {31'd0, b0.readBusy[1]}, 32'd0);
        check("sb_val_ab", rv0(1), 32'h000000AB);

        wr0(1, 1'b1, 5'd9, 32'h000000CD);
        rsv0(1'b1, 5'd9);
        tick();
        wr0(1, 1'b0, 5'd0, 32'h0);
        rsv0(1'b0, 5'd0);
        #1;
        check("sb_rsv_wr_busy", {31'd0, b0.readBusy[1]}, 32'd1);
        check("sb_rsv_wr_val", rv0(1), 32'h000000CD);
        rsv0(1'b1, 5'd9);
        tick();
        rsv0(1'b0, 5'd0);
        #1;
        check("sb_rereserve", {31'd0, b0.readBusy[1]}, 32'd1);

        wr0(0, 1'b1, 5'd12, 32'h0000005A);
        ra0(0, 5'd12);
        tick();
        wr0(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("sb_nonbusy_write_busy", {31'd0, b0.readBusy[0]}, 32'd0);
        check("sb_nonbusy_write_val", rv0(0), 32'h0000005A);

        // ZERO_REG=0: r0 behaves as an ordinary register
        b1.writeEnable[0]   = 1'b1;
        b1.writeAddr[4:0]   = 5'd0;
        b1.writeValue[31:0] = 32'hFFFFFFFF;
        b1.reserveEnable    = 1'b1;
        b1.reserveAddr      = 5'd0;
        b1.readAddr[4:0]    = 5'd0;
        #1;
        check("nz_r0_bypass", b1.readValue[31:0], 32'hFFFFFFFF);
        tick();
        b1.writeEnable   = '0;
        b1.reserveEnable = 1'b0;
        #1;
        check("nz_r0_val", b1.readValue[31:0], 32'hFFFFFFFF);
        check("nz_r0_busy", {31'd0, b1.readBusy[0]}, 32'd1);

        // Narrow build: fill r1..r7 then read across four ports
        for (int i = 1; i < 8; i++) begin
            b2.writeEnable = 1'b1;
            b2.writeAddr   = 3'(i);
            b2.writeValue  = 16'hA000 | 16'(i);
            tick();
        end
        b2.writeEnable = '0;
        b2.readAddr = {3'd4, 3'd3, 3'd2, 3'd1};
        #1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("narrow_rd_p%0d", j), {16'd0, rv2(j)}, {16'd0, 16'hA000 | 16'(j + 1)});
        end
        b2.readAddr = {3'd0, 3'd7, 3'd6, 3'd5};
        #1;
        check("narrow_r5", {16'd0, rv2(0)}, 32'h0000A005);
        check("narrow_r6", {16'd0, rv2(1)}, 32'h0000A006);
        check("narrow_r7", {16'd0, rv2(2)}, 32'h0000A007);
        check("narrow_r0", {16'd0, rv2(3)}, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
